// File: rtl/dcm_ctrl.sv
// dcm_ctrl: programs a clock divider's selection and supervises the acknowledge.
// The user steps a pending selection with inc/dec edges. An apply edge issues
// that selection with a one-cycle update strobe. The controller then waits for
// the divider to echo it back on prog_ack, re-issuing on timeout and parking in
// ERROR once the retry budget is spent.
module dcm_ctrl #(
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       apply,
    input  logic [2:0] prog_ack,
    output logic       update,
    output logic [2:0] prog_in,
    output logic [2:0] pending,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic          inc_q;
    logic          dec_q;
    logic          apply_q;

    logic inc_edge;
    logic dec_edge;
    logic apply_edge;
    logic ack_match;

    assign inc_edge   = inc & ~inc_q;
    assign dec_edge   = dec & ~dec_q;
    assign apply_edge = apply & ~apply_q;
    assign ack_match  = (prog_ack == prog_in);

    // Registered copies of the user inputs for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            apply_q <= 1'b0;
        end else begin
            inc_q   <= inc;
            dec_q   <= dec;
            apply_q <= apply;
        end
    end

    // Saturating pending selection. It updates in every state, and
    // simultaneous inc and dec edges cancel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (inc_edge && !dec_edge && pending != 3'd7) begin
            pending <= pending + 3'd1;
        end else if (dec_edge && !inc_edge && pending != 3'd0) begin
            pending <= pending - 3'd1;
        end
    end

    // Programming sequencer. Every output is registered alongside the state.
    // A match in WAIT is tested before the timeout, so a late echo still wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            retry   <= '0;
            prog_in <= '0;
            update  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            update <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (apply_edge) begin
                        state   <= S_ISSUE;
                        update  <= 1'b1;
                        prog_in <= pending;
                        timer   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    timer <= '0;
                end
                S_WAIT: begin
                    if (ack_match) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (timer == TIMER_LIMIT) begin
                        if (retry < RETRY_LIMIT) begin
                            state   <= S_ISSUE;
                            retry   <= retry + 1'b1;
                            update  <= 1'b1;
                            prog_in <= pending;
                            timer   <= '0;
                        end else begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    retry <= '0;
                    busy  <= 1'b0;
                end
                S_ERROR: begin
                    if (apply_edge) begin
                        state   <= S_ISSUE;
                        retry   <= '0;
                        error   <= 1'b0;
                        update  <= 1'b1;
                        prog_in <= pending;
                        timer   <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_ctrl.sv
// tb_dcm_ctrl: directed and randomized checks of dcm_ctrl. A latency-programmable
// divider model answers the update strobes. Expected timing for each apply is
// worked out arithmetically from the issue/timeout/retry rules.
module tb_dcm_ctrl;

    localparam int TIMEOUT   = 15;
    localparam int MAX_RETRY = 2;
    localparam int WINDOW    = TIMEOUT + 2;   // ISSUE-to-ISSUE spacing on retry
    localparam int RUN       = 1 + (MAX_RETRY + 1) * WINDOW + 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inc   = 1'b0;
    logic       dec   = 1'b0;
    logic       apply = 1'b0;
    logic [2:0] prog_ack;
    logic       update;
    logic [2:0] prog_in;
    logic [2:0] pending;
    logic       busy;
    logic       done;
    logic       error;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_pend = 0;
    int div_lat  = 1;   // cycles from update to echo; 0 means never echoes

    dcm_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .apply    (apply),
        .prog_ack (prog_ack),
        .update   (update),
        .prog_in  (prog_in),
        .pending  (pending),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Divider model: latches prog_in on update and echoes it div_lat cycles later.
    logic [2:0] div_val;
    int         div_cnt;
    bit         div_armed;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            prog_ack  <= '0;
            div_val   <= '0;
            div_cnt   <= 0;
            div_armed <= 1'b0;
        end else if (update) begin
            div_val <= prog_in;
            if (div_lat == 1) begin
                prog_ack  <= prog_in;
                div_armed <= 1'b0;
            end else begin
                div_cnt   <= 1;
                div_armed <= (div_lat != 0);
            end
        end else if (div_armed) begin
            if (div_cnt + 1 == div_lat) begin
                prog_ack  <= div_val;
                div_armed <= 1'b0;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int clamp7(input int v);
        return (v < 0) ? 0 : ((v > 7) ? 7 : v);
    endfunction

    task automatic pulse(input bit i, input bit d);
        inc = i;
        dec = d;
        tick();
        inc = 1'b0;
        dec = 1'b0;
        tick();
        if (i && !d)
            exp_pend = clamp7(exp_pend + 1);
        else if (d && !i)
            exp_pend = clamp7(exp_pend - 1);
    endtask

    // One apply transaction. Time t counts clock edges after the apply edge.
    task automatic run_apply(input string tag, input int lat, input bit inject);
        logic [2:0] p;
        logic [2:0] a;
        int n_upd, first_upd, last_upd, done_t, err_t, busy_n, bad_pin, dbl;
        int e_done, e_err, e_nupd, e_last, e_busy;
        bit prev;
        div_lat = lat;
        p = 3'(exp_pend);
        a = prog_ack;
        if (a == p) begin
            e_done = 3; e_err = -1; e_nupd = 1;
        end else if (lat >= 1) begin
            e_done = lat + 2; e_err = -1; e_nupd = 1;
        end else begin
            e_done = -1; e_err = 1 + (MAX_RETRY + 1) * WINDOW; e_nupd = MAX_RETRY + 1;
        end
        e_last = 1 + (e_nupd - 1) * WINDOW;
        e_busy = (e_done > 0) ? e_done : e_err - 1;
        n_upd = 0; first_upd = -1; last_upd = -1; done_t = -1; err_t = -1;
        busy_n = 0; bad_pin = 0; dbl = 0; prev = 1'b0;
        apply = 1'b1;
        tick();
        apply = 1'b0;
        for (int t = 1; t <= RUN; t++) begin
            if (update) begin
                n_upd++;
                if (first_upd < 0) first_upd = t;
                last_upd = t;
                if (prog_in !== p) bad_pin++;
            end
            if (update && prev) dbl++;
            prev = update;
            if (busy) busy_n++;
            if (done && done_t < 0) done_t = t;
            if (error && err_t < 0) err_t = t;
            if (inject && t == 2) apply = 1'b1;
            if (inject && t == 3) apply = 1'b0;
            if (inject && t == 4) inc = 1'b1;
            if (inject && t == 5) inc = 1'b0;
            tick();
        end
        if (inject) exp_pend = clamp7(exp_pend + 1);
        check({tag, "_first_upd"}, first_upd, 1);
        check({tag, "_n_upd"}, n_upd, e_nupd);
        check({tag, "_last_upd"}, last_upd, e_last);
        check({tag, "_done_t"}, done_t, e_done);
        check({tag, "_err_t"}, err_t, e_err);
        check({tag, "_busy_cycles"}, busy_n, e_busy);
        check({tag, "_bad_prog_in"}, bad_pin, 0);
        check({tag, "_dbl_update"}, dbl, 0);
        check({tag, "_prog_in"}, prog_in, p);
        check({tag, "_pending"}, pending, exp_pend);
        check({tag, "_error_end"}, error, (e_err > 0) ? 1 : 0);
    endtask

    initial begin
        int n_up;
        // Reset values, with inc held high through release.
        inc = 1'b1;
        tick();
        tick();
        check("rst_outputs", {update, prog_in, pending, busy, done, error}, 0);
        reset = 1'b1;
        tick();
        exp_pend = 1;
        check("rst_release_edge", pending, 1);
        inc = 1'b0;
        tick();

        // Saturation and simultaneous edges.
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
        check("sat_high", pending, 7);
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1);
        check("sat_low", pending, 0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        check("inc_dec_same", pending, 2);

        // Nominal apply of 3, then re-apply of the already-active value.
        pulse(1'b1, 1'b0);
        run_apply("nominal", 1, 1'b0);
        run_apply("same_val", 1, 1'b0);

        // Bring the divider to 0, then apply 5 with the divider stuck: timeout, retries, ERROR.
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        run_apply("to_zero", 2, 1'b0);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        run_apply("stuck", 0, 1'b0);
        run_apply("recover", 1, 1'b0);

        // Echo lands on the very cycle the timer reaches TIMEOUT.
        pulse(1'b1, 1'b0);
        run_apply("late_match", TIMEOUT + 1, 1'b0);

        // apply and inc pulses while in WAIT.
        pulse(1'b0, 1'b1);
        run_apply("wait_inputs", 5, 1'b1);

        // Randomized transactions.
        for (int k = 0; k < 20; k++) begin
            int ops;
            int lat;
            ops = $urandom_range(1, 6);
            for (int j = 0; j < ops; j++) begin
                case ($urandom_range(0, 4))
                    0, 1: pulse(1'b1, 1'b0);
                    2, 3: pulse(1'b0, 1'b1);
                    default: pulse(1'b1, 1'b1);
                endcase
            end
            check("rand_pending", pending, exp_pend);
            lat = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT + 1);
            run_apply("rand", lat, (lat > 0) ? bit'($urandom_range(0, 1)) : 1'b0);
        end

        // Asynchronous reset while in WAIT; no update may follow release.
        div_lat = 0;
        pulse(1'b1, 1'b0);
        apply = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_outputs", {update, prog_in, pending, busy, done, error}, 0);
        tick();
        tick();
        reset = 1'b1;
        exp_pend = 0;
        n_up = 0;
        for (int t = 0; t < 25; t++) begin
            if (update) n_up++;
            tick();
        end
        check("post_rst_updates", n_up, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_pending", pending, exp_pend);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcm_ctrl.md
DCM_CTRL -- requirements
Module: dcm_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: WAIT-state cycles allowed before a retry.
REQ-002 Parameter MAX_RETRY, default 2: re-issues allowed before ERROR.
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; assertion (0) clears all state immediately, release is sampled on clock.
REQ-005 inc  in  1  level; rising edge increments the pending divider selection.
REQ-006 dec  in  1  level; rising edge decrements the pending divider selection.
REQ-007 apply  in  1  level; rising edge requests programming of the pending selection into the divider.
REQ-008 prog_ack  in  3  divider's echoed active selection (driven by the divider's prog_out).
REQ-009 update  out  1  one-cycle program strobe to the divider.
REQ-010 prog_in  out  3  selection presented to the divider; stable from ISSUE until the next ISSUE.
REQ-011 pending  out  3  user-selected value not yet necessarily applied.
REQ-012 busy  out  1  high in ISSUE, WAIT and DONE.
REQ-013 done  out  1  one-cycle pulse on successful acknowledge.
REQ-014 error  out  1  high while in ERROR.

Function
REQ-015 Edge detection: registered copies inc_q, dec_q, apply_q; edge = signal AND NOT registered copy, same cycle.
REQ-016 inc edge alone: pending saturates at 7 (7 stays 7); dec edge alone: pending saturates at 0.
REQ-017 inc and dec edges in the same cycle: pending unchanged.
REQ-018 inc/dec edges are honoured in every state, including busy; prog_in is unaffected.
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE, ERROR.
REQ-020 IDLE: apply edge -> ISSUE next cycle; otherwise remain.
REQ-021 ISSUE (one cycle): update=1; prog_in loads pending at entry; WAIT timer cleared; -> WAIT.
REQ-022 WAIT: if prog_ack == prog_in -> DONE; else timer increments; when timer reaches TIMEOUT with no match -> ISSUE if retry count < MAX_RETRY (retry count +1), else ERROR.
REQ-023 Match has priority over timeout in the same cycle.
REQ-024 DONE (one cycle): done=1, retry count cleared; -> IDLE.
REQ-025 ERROR: error=1; apply edge -> ISSUE with retry count cleared and error deasserted from the ISSUE cycle.
REQ-026 apply edges in ISSUE, WAIT or DONE are ignored (not queued).
REQ-027 Nominal latency: apply edge in cycle N -> update=1 in N+1 -> WAIT in N+2 -> done=1 in N+3 when divider acknowledges immediately.
REQ-028 Applying a value equal to the current prog_ack still issues update and completes normally.
REQ-029 update is never high for two consecutive cycles.

Reset
REQ-030 While reset=0: state IDLE, update=0, prog_in=0, pending=0, busy=0, done=0, error=0, timer=0, retry count=0, inc_q/dec_q/apply_q=0.
REQ-031 Reset asserted mid-operation (any state) aborts immediately to REQ-030 values; no update pulse follows release.
REQ-032 An input held high through reset release produces an edge on the first clock after release (registered copy is 0).

Verification
REQ-033 Three inc pulses, then apply; divider model echoes next cycle -> pending=3, update=1 one cycle with prog_in=3, done=1 exactly 3 cycles after apply edge, busy high 3 cycles.
REQ-034 Ten inc pulses then ten dec pulses -> pending saturates at 7, then at 0; simultaneous inc+dec edge -> no change.
REQ-035 prog_ack stuck at 0, apply with pending=5, TIMEOUT=15, MAX_RETRY=2 -> three update pulses spaced 17 cycles apart, then error=1, busy=0; next apply edge with responsive model -> error=0, done=1.
REQ-036 Match arriving in the same cycle the timer hits TIMEOUT -> DONE, no retry update.
REQ-037 apply pulses during WAIT and inc during WAIT -> no extra update; prog_in unchanged; pending incremented.
REQ-038 reset=0 asserted during WAIT -> all outputs to reset values asynchronously; after release, no update until a fresh apply edge.
